d16_uart: RTL and testbench

- Wishbone responder for the d16 CPU bus: a memory-mapped 8N1 UART with a TX holding register plus shifter, and an RX sampler feeding a small FIFO.
- It is the target end of the CPU's single-cycle, no-ack bus.
- Read data is combinational in the access cycle.
- Writes are captured on the rising clock edge that ends the access cycle.
- o_wb_dat is zero when the block is not selected, so responders can be OR-combined.

---
 rtl/d16_uart.sv | 230 +++++++++++++++++++++++
 tb/tb_d16_uart.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d16_uart.sv
// d16_uart: Wishbone-mapped 8N1 UART for the d16 CPU bus. It has a TX holding register feeding a shifter,
// and an RX sampler feeding a small FIFO. Reads are combinational and writes land on the closing edge.
module d16_uart #(
  parameter logic [15:0] BASE_ADDR     = 16'hFF00,
  parameter logic [15:0] CLKDIV_RESET  = 16'd217,
  parameter int          RX_DEPTH_LOG2 = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_int
);

  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] FULL_COUNT = (RX_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic        sel, wr, rd;
  logic [1:0]  reg_idx;
  logic [15:0] div, div_eff, div_half;
  logic [1:0]  ctrl;
  logic        rx_overrun, frame_err;

  assign sel      = i_wb_cyc && (i_wb_addr[15:2] == BASE_ADDR[15:2]);
  assign reg_idx  = i_wb_addr[1:0];
  assign wr       = sel && i_wb_we;
  assign rd       = sel && !i_wb_we;
  assign div_eff  = (div < 16'd2) ? 16'd2 : div;
  assign div_half = {1'b0, div_eff[15:1]};

  // ---------------- TX ----------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift, hold_data;
  logic        hold_full, tx_load, tx_tick, tx_busy;

  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_busy = hold_full || (tx_state != TX_IDLE);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE:  if (hold_full) begin tx_next = TX_START; tx_load = 1'b1; end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:
        if (tx_tick) begin
          if (hold_full) begin tx_next = TX_START; tx_load = 1'b1; end
          else tx_next = TX_IDLE;
        end
      default:  tx_next = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      o_tx      <= 1'b1;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (tx_load) begin
        tx_shift <= hold_data;
        o_tx     <= 1'b0;
        tx_cnt   <= div_eff - 16'd1;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          // A reload at each bit boundary lets a DIV write take effect on the next bit.
          tx_cnt <= div_eff - 16'd1;
          if (tx_state == TX_START) begin
            o_tx     <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= 3'd0;
          end else if (tx_state == TX_DATA) begin
            o_tx     <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt - 16'd1;
        end
      end
      if (tx_load) hold_full <= 1'b0;
      else if (wr && reg_idx == 2'd0 && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= i_wb_dat[7:0];
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t   rx_state, rx_next;
  logic        rx_meta, rxs, rx_tick, rx_push, rx_ferr;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign rx_tick = (rx_cnt == 16'd0);

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rxs) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:
        if (rx_tick) begin
          if (rxs) begin rx_push = 1'b1; rx_next = RX_IDLE; end
          else     begin rx_ferr = 1'b1; rx_next = RX_BREAK; end
        end
      RX_BREAK: if (rxs) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
      case (rx_state)
        RX_IDLE:  if (!rxs) rx_cnt <= div_half - 16'd1;
        RX_START:
          if (rx_tick) begin rx_cnt <= div_eff - 16'd1; rx_bit <= 3'd0; end
          else rx_cnt <= rx_cnt - 16'd1;
        RX_DATA:
          if (rx_tick) begin
            rx_shift <= {rxs, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_cnt   <= div_eff - 16'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        RX_STOP:  if (!rx_tick) rx_cnt <= rx_cnt - 16'd1;
        default:  ;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]               fifo_mem [DEPTH];
  logic [RX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [RX_DEPTH_LOG2:0]   count;
  logic                     rx_avail, rx_full, pop, push_ok;

  assign rx_avail = (count != '0);
  assign rx_full  = (count == FULL_COUNT);
  assign pop      = rd && reg_idx == 2'd0 && rx_avail;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = rx_push && (!rx_full || pop);

  // NOTE: the FIFO storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge i_clk)
    if (push_ok) fifo_mem[wr_ptr] <= rx_shift;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  // ---------------- Control registers ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div        <= CLKDIV_RESET;
      ctrl       <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr && reg_idx == 2'd1) begin
        if (i_wb_dat[4]) rx_overrun <= 1'b0;
        if (i_wb_dat[5]) frame_err  <= 1'b0;
      end
      if (wr && reg_idx == 2'd2) div  <= i_wb_dat;
      if (wr && reg_idx == 2'd3) ctrl <= i_wb_dat[1:0];
      // A new event on the same edge as a clear takes priority.
      if (rx_push && rx_full && !pop) rx_overrun <= 1'b1;
      if (rx_ferr) frame_err <= 1'b1;
    end
  end

  always_comb begin
    o_wb_dat = '0;
    if (rd) begin
      case (reg_idx)
        2'd0: o_wb_dat = rx_avail ? {8'd0, fifo_mem[rd_ptr]} : 16'd0;
        2'd1: o_wb_dat = {10'd0, frame_err, rx_overrun, hold_full, tx_busy, rx_full, rx_avail};
        2'd2: o_wb_dat = div;
        default: o_wb_dat = {14'd0, ctrl};
      endcase
    end
  end

  assign o_int = (ctrl[0] && rx_avail) || (ctrl[1] && !tx_busy);

endmodule

// File: tb/tb_d16_uart.sv
// Directed bench for d16_uart. o_tx is logged on every rising edge, and frames are compared against a bit-level model afterwards.
module tb_d16_uart;

  localparam logic [15:0] A_DATA = 16'hFF00;
  localparam logic [15:0] A_STAT = 16'hFF01;
  localparam logic [15:0] A_DIV  = 16'hFF02;
  localparam logic [15:0] A_CTRL = 16'hFF03;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_wb_addr = '0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [15:0] i_wb_dat = '0;
  logic [15:0] o_wb_dat;
  logic        i_rx = 1'b1;
  logic        o_tx, o_int;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc  = 0;
  logic tx_log [0:16383];

  always #5 i_clk = ~i_clk;

  d16_uart dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_addr(i_wb_addr), .i_wb_cyc(i_wb_cyc),
    .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat),
    .i_rx(i_rx), .o_tx(o_tx), .o_int(o_int)
  );

  // tx_log[i] holds o_tx as it stands after rising edge i.
  always @(posedge i_clk) begin
    #2;
    tx_log[ncyc] = o_tx;
    ncyc = ncyc + 1;
  end

  // Expected serial level k clocks into a frame: start bit, 8 data bits LSB first, then the stop bit.
  function automatic logic frame_bit(input logic [7:0] b, input int div, input int k);
    int p;
    p = k / div;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  // The bus tasks start and end at a falling edge.
  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    i_wb_addr = a; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
    #1 d = o_wb_dat;
    i_wb_cyc = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, output int w);
    i_wb_addr = a; i_wb_dat = d; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
    @(negedge i_clk);
    i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    w = ncyc - 1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    i_wb_addr = a; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
    #1 d = o_wb_dat;
    @(negedge i_clk);
    i_wb_cyc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int div, input logic stop);
    i_rx = 1'b0;
    repeat (div) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (div) @(negedge i_clk);
    end
    i_rx = stop;
    repeat (div) @(negedge i_clk);
    i_rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    @(negedge i_clk);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL reset_status: got %h expected 0000", d); end
    peek(A_DIV, d);
    n_cmp++; if (d !== 16'd217) begin n_err++; $display("FAIL reset_div: got %h expected 00d9", d); end
    n_cmp++; if (o_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", o_tx); end
    n_cmp++; if (o_int !== 1'b0) begin n_err++; $display("FAIL reset_int: got %b expected 0", o_int); end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_tx_frame;
    logic [15:0] d;
    int w;
    bus_write(A_DIV, 16'd4, w);
    peek(A_DIV, d);
    n_cmp++; if (d !== 16'd4) begin n_err++; $display("FAIL div_write: got %h expected 0004", d); end
    bus_write(A_DATA, 16'h00A5, w);
    n_cmp++; if (tx_log[w] !== 1'b1) begin n_err++; $display("FAIL tx_latency: got %b expected 1 at write edge", tx_log[w]); end
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h000C) begin n_err++; $display("FAIL tx_hold_status: got %h expected 000c", d); end
    repeat (40) @(negedge i_clk);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0004) begin n_err++; $display("FAIL tx_busy_stop: got %h expected 0004", d); end
    @(negedge i_clk);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL tx_busy_end: got %h expected 0000", d); end
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (tx_log[w+1+k] !== frame_bit(8'hA5, 4, k)) begin
        n_err++; $display("FAIL tx_a5_bit%0d: got %b expected %b", k, tx_log[w+1+k], frame_bit(8'hA5, 4, k));
      end
    end
    n_cmp++; if (tx_log[w+41] !== 1'b1) begin n_err++; $display("FAIL tx_a5_idle: got %b expected 1", tx_log[w+41]); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    int w, w2;
    bus_write(A_DATA, 16'h0011, w);
    @(negedge i_clk);
    bus_write(A_DATA, 16'h0022, w2);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h000C) begin n_err++; $display("FAIL b2b_status: got %h expected 000c", d); end
    bus_write(A_DATA, 16'h0033, w2);
    repeat (100) @(negedge i_clk);
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (tx_log[w+1+k] !== frame_bit(8'h11, 4, k)) begin
        n_err++; $display("FAIL b2b_11_bit%0d: got %b expected %b", k, tx_log[w+1+k], frame_bit(8'h11, 4, k));
      end
      n_cmp++;
      if (tx_log[w+41+k] !== frame_bit(8'h22, 4, k)) begin
        n_err++; $display("FAIL b2b_22_bit%0d: got %b expected %b", k, tx_log[w+41+k], frame_bit(8'h22, 4, k));
      end
    end
    for (int k = 81; k <= 100; k++) begin
      n_cmp++;
      if (tx_log[w+k] !== 1'b1) begin n_err++; $display("FAIL b2b_drop33_%0d: got %b expected 1", k, tx_log[w+k]); end
    end
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL b2b_final_status: got %h expected 0000", d); end
  endtask

  task automatic test_div_min;
    logic [15:0] d;
    int w;
    bus_write(A_DIV, 16'd1, w);
    peek(A_DIV, d);
    n_cmp++; if (d !== 16'd1) begin n_err++; $display("FAIL div1_read: got %h expected 0001", d); end
    bus_write(A_DATA, 16'h000F, w);
    repeat (25) @(negedge i_clk);
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (tx_log[w+1+k] !== frame_bit(8'h0F, 2, k)) begin
        n_err++; $display("FAIL div1_bit%0d: got %b expected %b", k, tx_log[w+1+k], frame_bit(8'h0F, 2, k));
      end
    end
    n_cmp++; if (tx_log[w+21] !== 1'b1) begin n_err++; $display("FAIL div1_idle: got %b expected 1", tx_log[w+21]); end
    bus_write(A_DIV, 16'd4, w);
  endtask

  task automatic test_rx;
    logic [15:0] d;
    send_byte(8'h3C, 4, 1'b1);
    repeat (3) @(negedge i_clk);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0001) begin n_err++; $display("FAIL rx_avail: got %h expected 0001", d); end
    bus_read(A_DATA, d);
    n_cmp++; if (d !== 16'h003C) begin n_err++; $display("FAIL rx_data: got %h expected 003c", d); end
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rx_popped: got %h expected 0000", d); end
    bus_read(A_DATA, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rx_empty_read: got %h expected 0000", d); end
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rx_no_underflow: got %h expected 0000", d); end
    i_rx = 1'b0;
    @(negedge i_clk);
    i_rx = 1'b1;
    repeat (20) @(negedge i_clk);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rx_glitch: got %h expected 0000", d); end
  endtask

  task automatic test_fifo;
    logic [15:0] d;
    int w;
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 4, 1'b1);
    repeat (3) @(negedge i_clk);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0013) begin n_err++; $display("FAIL fifo_full_status: got %h expected 0013", d); end
    for (int b = 1; b <= 4; b++) begin
      bus_read(A_DATA, d);
      n_cmp++; if (d !== 16'(b)) begin n_err++; $display("FAIL fifo_read%0d: got %h expected %h", b, d, 16'(b)); end
    end
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0010) begin n_err++; $display("FAIL fifo_overrun_sticky: got %h expected 0010", d); end
    bus_write(A_STAT, 16'h0010, w);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL fifo_overrun_clear: got %h expected 0000", d); end
  endtask

  task automatic test_frame_err;
    logic [15:0] d;
    int w;
    send_byte(8'h55, 4, 1'b0);
    repeat (6) @(negedge i_clk);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0020) begin n_err++; $display("FAIL frame_err_set: got %h expected 0020", d); end
    bus_write(A_STAT, 16'h0020, w);
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL frame_err_clear: got %h expected 0000", d); end
  endtask

  task automatic test_interrupt;
    logic [15:0] d;
    int w;
    bus_write(A_CTRL, 16'h0003, w);
    n_cmp++; if (o_int !== 1'b1) begin n_err++; $display("FAIL int_tx_ie: got %b expected 1", o_int); end
    peek(A_CTRL, d);
    n_cmp++; if (d !== 16'h0003) begin n_err++; $display("FAIL ctrl_read: got %h expected 0003", d); end
    bus_write(A_CTRL, 16'h0001, w);
    n_cmp++; if (o_int !== 1'b0) begin n_err++; $display("FAIL int_rx_ie_empty: got %b expected 0", o_int); end
    send_byte(8'h5A, 4, 1'b1);
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_int !== 1'b1) begin n_err++; $display("FAIL int_rx_avail: got %b expected 1", o_int); end
    bus_read(A_DATA, d);
    n_cmp++; if (d !== 16'h005A) begin n_err++; $display("FAIL int_rx_data: got %h expected 005a", d); end
    n_cmp++; if (o_int !== 1'b0) begin n_err++; $display("FAIL int_rx_cleared: got %b expected 0", o_int); end
    bus_write(A_CTRL, 16'hFFFE, w);
    peek(A_CTRL, d);
    n_cmp++; if (d !== 16'h0002) begin n_err++; $display("FAIL ctrl_mask: got %h expected 0002", d); end
    n_cmp++; if (o_int !== 1'b1) begin n_err++; $display("FAIL int_tx_only: got %b expected 1", o_int); end
    bus_write(A_CTRL, 16'h0000, w);
  endtask

  task automatic test_out_of_range;
    logic [15:0] d;
    int w;
    bus_write(16'hFF06, 16'h1234, w);
    bus_write(16'hFEFE, 16'h0009, w);
    bus_write(16'hFF04, 16'h0077, w);
    bus_write(16'hFF07, 16'h0003, w);
    repeat (4) @(negedge i_clk);
    peek(A_DIV, d);
    n_cmp++; if (d !== 16'd4) begin n_err++; $display("FAIL oor_div: got %h expected 0004", d); end
    peek(16'hFF06, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL oor_read_hi: got %h expected 0000", d); end
    peek(16'hFEFD, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL oor_read_lo: got %h expected 0000", d); end
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL oor_status: got %h expected 0000", d); end
    peek(A_CTRL, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL oor_ctrl: got %h expected 0000", d); end
    n_cmp++; if (o_tx !== 1'b1) begin n_err++; $display("FAIL oor_tx: got %b expected 1", o_tx); end
    i_wb_addr = A_DIV; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
    #1;
    n_cmp++; if (o_wb_dat !== 16'h0000) begin n_err++; $display("FAIL unselected_read: got %h expected 0000", o_wb_dat); end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] d;
    int w;
    bus_write(A_DATA, 16'h0000, w);
    repeat (6) @(negedge i_clk);
    n_cmp++; if (o_tx !== 1'b0) begin n_err++; $display("FAIL midreset_pre: got %b expected 0", o_tx); end
    i_reset = 1'b1;
    #1;
    n_cmp++; if (o_tx !== 1'b1) begin n_err++; $display("FAIL midreset_tx: got %b expected 1", o_tx); end
    n_cmp++; if (o_int !== 1'b0) begin n_err++; $display("FAIL midreset_int: got %b expected 0", o_int); end
    peek(A_DIV, d);
    n_cmp++; if (d !== 16'd217) begin n_err++; $display("FAIL midreset_div: got %h expected 00d9", d); end
    i_reset = 1'b0;
    repeat (10) @(negedge i_clk);
    n_cmp++; if (o_tx !== 1'b1) begin n_err++; $display("FAIL midreset_idle: got %b expected 1", o_tx); end
    peek(A_STAT, d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL midreset_status: got %h expected 0000", d); end
  endtask

  initial begin
    test_reset;
    test_tx_frame;
    test_back_to_back;
    test_div_min;
    test_rx;
    test_fifo;
    test_frame_err;
    test_interrupt;
    test_out_of_range;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
